// File: rtl/wave_recorder_pkg.sv
// Shared widths and state encodings for the wave memory capture/playback path.
package wave_recorder_pkg;

  localparam int unsigned ADDR_SIZE  = 16;
  localparam int unsigned RESET_SIZE = 10;
  localparam int unsigned DATA_SIZE  = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REC  = 1'b1
  } rec_state_e;

endpackage

// File: rtl/wave_recorder_offset_ctr.sv
// Window offset counter: clears to zero, steps on each accepted sample and
// flags when the current offset equals the last offset of the window.
module wave_recorder_offset_ctr #(
  parameter int unsigned width = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             inc,
  input  logic [width-1:0] last,
  output logic [width-1:0] offset,
  output logic             last_hit_c
);

  logic [width-1:0] offset_q;
  logic [width-1:0] offset_d;

  // The increment cannot overflow because it is never requested at last.
  always_comb begin
    offset_d = offset_q;
    if (clear) begin
      offset_d = '0;
    end else if (inc) begin
      offset_d = offset_q + width'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      offset_q <= '0;
    end else begin
      offset_q <= offset_d;
    end
  end

  assign offset     = offset_q;
  assign last_hit_c = (offset_q == last);

endmodule

// File: rtl/wave_recorder.sv
// Wave memory write side: streams accepted samples into beg_addr..beg_addr+reset_val,
// one capture per start, with a done pulse on the final RAM write.
module wave_recorder
  import wave_recorder_pkg::*;
#(
  parameter int unsigned addr_size  = ADDR_SIZE,
  parameter int unsigned reset_size = RESET_SIZE,
  parameter int unsigned data_size  = DATA_SIZE
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  start,
  input  logic [addr_size-1:0]  beg_addr,
  input  logic [reset_size-1:0] reset_val,
  input  logic [data_size-1:0]  sample_in,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic                  wr_en,
  output logic [addr_size-1:0]  wr_addr,
  output logic [data_size-1:0]  wr_data,
  output logic                  busy,
  output logic                  done
);

  rec_state_e            state_q, state_d;
  logic [addr_size-1:0]  base_q, base_d;
  logic [reset_size-1:0] last_q, last_d;
  logic                  wr_en_q, wr_en_d;
  logic [addr_size-1:0]  wr_addr_q, wr_addr_d;
  logic [data_size-1:0]  wr_data_q, wr_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  ready_c;
  logic                  accept_c;
  logic                  start_ok_c;
  logic                  abort_c;
  logic                  ctr_clear_c;
  logic                  ctr_inc_c;
  logic                  last_hit_c;
  logic [reset_size-1:0] offset;

  // Ready depends only on state and enable, never on sample_valid.
  assign ready_c      = (state_q == ST_REC) && enable;
  assign accept_c     = ready_c && sample_valid;
  assign start_ok_c   = (state_q == ST_IDLE) && start && enable;
  assign abort_c      = (state_q == ST_REC) && !enable;
  assign ctr_clear_c  = start_ok_c || abort_c || (accept_c && last_hit_c);
  assign ctr_inc_c    = accept_c && !last_hit_c;
  assign sample_ready = ready_c;

  wave_recorder_offset_ctr #(
    .width(reset_size)
  ) u_offset_ctr (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (ctr_clear_c),
    .inc       (ctr_inc_c),
    .last      (last_q),
    .offset    (offset),
    .last_hit_c(last_hit_c)
  );

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    last_d    = last_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    wr_en_d   = accept_c;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (accept_c) begin
      wr_addr_d = base_q + addr_size'(offset);
      wr_data_d = sample_in;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start_ok_c) begin
          state_d = ST_REC;
          base_d  = beg_addr;
          last_d  = reset_val;
          busy_d  = 1'b1;
        end
      end
      ST_REC: begin
        if (!enable) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else if (accept_c && last_hit_c) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      base_q    <= '0;
      last_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      last_q    <= last_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_wave_recorder.sv
// Directed vector bench for wave_recorder: per-cycle stimulus with expected
// ready/write/busy/done, plus long-capture and async-reset sequences.
module tb_wave_recorder;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic        start;
  logic [15:0] beg_addr;
  logic [9:0]  reset_val;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic        sample_ready;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        en;
    logic        st;
    logic [15:0] ba;
    logic [9:0]  rv;
    logic        v;
    logic [15:0] d;
    logic        rdy;
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
    logic        bsy;
    logic        dn;
  } vec_t;

  vec_t vecs[$];

  wave_recorder dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .start       (start),
    .beg_addr    (beg_addr),
    .reset_val   (reset_val),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic en, input logic st, input logic [15:0] ba,
                              input logic [9:0] rv, input logic v, input logic [15:0] d,
                              input logic rdy, input logic we, input logic [15:0] addr,
                              input logic [15:0] data, input logic bsy, input logic dn);
    vec_t r;
    r.en = en; r.st = st; r.ba = ba; r.rv = rv; r.v = v; r.d = d;
    r.rdy = rdy; r.we = we; r.addr = addr; r.data = data; r.bsy = bsy; r.dn = dn;
    return r;
  endfunction

  task automatic apply_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    enable       = v.en;
    start        = v.st;
    beg_addr     = v.ba;
    reset_val    = v.rv;
    sample_valid = v.v;
    sample_in    = v.d;
    #1;
    check({tag, ".sample_ready"}, 32'(sample_ready), 32'(v.rdy));
    @(posedge clk);
    #1;
    check({tag, ".wr_en"},   32'(wr_en),   32'(v.we));
    check({tag, ".wr_addr"}, 32'(wr_addr), 32'(v.addr));
    check({tag, ".wr_data"}, 32'(wr_data), 32'(v.data));
    check({tag, ".busy"},    32'(busy),    32'(v.bsy));
    check({tag, ".done"},    32'(done),    32'(v.dn));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".sample_ready"}, 32'(sample_ready), 32'd0);
    check({tag, ".wr_en"},        32'(wr_en),        32'd0);
    check({tag, ".wr_addr"},      32'(wr_addr),      32'd0);
    check({tag, ".wr_data"},      32'(wr_data),      32'd0);
    check({tag, ".busy"},         32'(busy),         32'd0);
    check({tag, ".done"},         32'(done),         32'd0);
  endtask

  initial begin
    // Basic capture: 0100..0103, four writes, done with last.
    vecs.push_back(mk(1,1,16'h0100,10'd3,0,16'h0000, 0,0,16'h0000,16'h0000,1,0));
    vecs.push_back(mk(1,0,16'h0000,10'd0,1,16'hA000, 1,1,16'h0100,16'hA000,1,0));
    vecs.push_back(mk(1,0,16'h0000,10'd0,1,16'hA001, 1,1,16'h0101,16'hA001,1,0));
    vecs.push_back(mk(1,0,16'h0000,10'd0,1,16'hA002, 1,1,16'h0102,16'hA002,1,0));
    vecs.push_back(mk(1,0,16'h0000,10'd0,1,16'hA003, 1,1,16'h0103,16'hA003,0,1));
    vecs.push_back(mk(1,0,16'h0000,10'd0,1,16'hA004, 0,0,16'h0103,16'hA003,0,0));
    // Stalled capture: valid 1,0,0,1,0,1 gives exactly three writes.
    vecs.push_back(mk(1,1,16'h0100,10'd2,0,16'h0000, 0,0,16'h0103,16'hA003,1,0));
    vecs.push_back(mk(1,0,16'h0000,10'd0,1,16'hB000, 1,1,16'h0100,16'hB000,1,0));
    vecs.push_back(mk(1,0,16'h0000,10'd0,0,16'hBEEF, 1,0,16'h0100,16'hB000,1,0));
    vecs.push_back(mk(1,0,16'h0000,10'd0,0,16'hBEEF, 1,0,16'h0100,16'hB000,1,0));
    vecs.push_back(mk(1,0,16'h0000,10'd0,1,16'hB001, 1,1,16'h0101,16'hB001,1,0));
    vecs.push_back(mk(1,0,16'h0000,10'd0,0,16'hBEEF, 1,0,16'h0101,16'hB001,1,0));
    vecs.push_back(mk(1,0,16'h0000,10'd0,1,16'hB002, 1,1,16'h0102,16'hB002,0,1));
    vecs.push_back(mk(1,0,16'h0000,10'd0,0,16'h0000, 0,0,16'h0102,16'hB002,0,0));
    // Address wrap at the top of RAM.
    vecs.push_back(mk(1,1,16'hFFFE,10'd3,0,16'h0000, 0,0,16'h0102,16'hB002,1,0));
    vecs.push_back(mk(1,0,16'h0000,10'd0,1,16'hC000, 1,1,16'hFFFE,16'hC000,1,0));
    vecs.push_back(mk(1,0,16'h0000,10'd0,1,16'hC001, 1,1,16'hFFFF,16'hC001,1,0));
    vecs.push_back(mk(1,0,16'h0000,10'd0,1,16'hC002, 1,1,16'h0000,16'hC002,1,0));
    vecs.push_back(mk(1,0,16'h0000,10'd0,1,16'hC003, 1,1,16'h0001,16'hC003,0,1));
    // Single-write capture (reset_val = 0).
    vecs.push_back(mk(1,1,16'h0200,10'd0,0,16'h0000, 0,0,16'h0001,16'hC003,1,0));
    vecs.push_back(mk(1,0,16'h0000,10'd0,1,16'hD000, 1,1,16'h0200,16'hD000,0,1));
    vecs.push_back(mk(1,0,16'h0000,10'd0,0,16'h0000, 0,0,16'h0200,16'hD000,0,0));
    // Abort after two writes, ignored starts, then restart from offset 0.
    vecs.push_back(mk(1,1,16'h0300,10'd5,0,16'h0000, 0,0,16'h0200,16'hD000,1,0));
    vecs.push_back(mk(1,0,16'h0000,10'd0,1,16'hE000, 1,1,16'h0300,16'hE000,1,0));
    vecs.push_back(mk(1,1,16'h0500,10'd0,1,16'hE001, 1,1,16'h0301,16'hE001,1,0));
    vecs.push_back(mk(0,0,16'h0000,10'd0,1,16'hE002, 0,0,16'h0301,16'hE001,0,0));
    vecs.push_back(mk(1,0,16'h0000,10'd0,1,16'hE003, 0,0,16'h0301,16'hE001,0,0));
    vecs.push_back(mk(0,1,16'h0700,10'd3,1,16'hE004, 0,0,16'h0301,16'hE001,0,0));
    vecs.push_back(mk(1,0,16'h0000,10'd0,1,16'hE005, 0,0,16'h0301,16'hE001,0,0));
    vecs.push_back(mk(1,1,16'h0300,10'd1,0,16'h0000, 0,0,16'h0301,16'hE001,1,0));
    vecs.push_back(mk(1,0,16'h0999,10'd7,1,16'hF000, 1,1,16'h0300,16'hF000,1,0));
    vecs.push_back(mk(1,0,16'h0000,10'd0,1,16'hF001, 1,1,16'h0301,16'hF001,0,1));

    reset_n      = 1'b0;
    enable       = 1'b0;
    start        = 1'b0;
    beg_addr     = '0;
    reset_val    = '0;
    sample_in    = '0;
    sample_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) apply_vec(i, vecs[i]);

    // Full-length capture: 1024 writes, done only on the last one.
    begin
      bit saw_done_early;
      int writes;
      saw_done_early = 1'b0;
      writes = 0;
      @(negedge clk);
      enable = 1'b1; start = 1'b1; beg_addr = 16'h1000; reset_val = 10'h3FF;
      sample_valid = 1'b0;
      @(posedge clk); #1;
      check("long.busy_start", 32'(busy), 32'd1);
      for (int i = 0; i < 1024; i++) begin
        @(negedge clk);
        start = 1'b0; sample_valid = 1'b1; sample_in = 16'(i) ^ 16'h5A5A;
        @(posedge clk); #1;
        if (wr_en === 1'b1) writes++;
        if (wr_addr !== 16'h1000 + 16'(i) || wr_data !== (16'(i) ^ 16'h5A5A))
          check($sformatf("long.write%0d", i), {wr_addr, wr_data},
                {16'h1000 + 16'(i), 16'(i) ^ 16'h5A5A});
        if (i < 1023 && (done !== 1'b0 || busy !== 1'b1)) saw_done_early = 1'b1;
      end
      check("long.writes", 32'(writes), 32'd1024);
      check("long.no_early_done", 32'(saw_done_early), 32'd0);
      check("long.last_addr", 32'(wr_addr), 32'h13FF);
      check("long.done", 32'(done), 32'd1);
      check("long.busy_end", 32'(busy), 32'd0);
      @(negedge clk);
      sample_valid = 1'b0;
      @(posedge clk); #1;
      check("long.done_pulse", 32'(done), 32'd0);
      check("long.wr_en_off", 32'(wr_en), 32'd0);
    end

    // Async reset asserted between edges mid-capture.
    @(negedge clk);
    enable = 1'b1; start = 1'b1; beg_addr = 16'h0700; reset_val = 10'd9;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = 1'b0; sample_valid = 1'b1; sample_in = 16'h7700 + 16'(i);
      @(posedge clk); #1;
    end
    check("arst.pre_we", 32'(wr_en), 32'd1);
    check("arst.pre_addr", 32'(wr_addr), 32'h0702);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("arst.during");
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      check($sformatf("arst.after_ready%0d", i), 32'(sample_ready), 32'd0);
      @(posedge clk); #1;
      check($sformatf("arst.after_we%0d", i), 32'(wr_en), 32'd0);
      check($sformatf("arst.after_busy%0d", i), 32'(busy), 32'd0);
    end
    @(negedge clk);
    start = 1'b1; beg_addr = 16'h0800; reset_val = 10'd0; sample_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    start = 1'b0; sample_valid = 1'b1; sample_in = 16'h8888;
    #1;
    check("arst.restart_ready", 32'(sample_ready), 32'd1);
    @(posedge clk); #1;
    check("arst.restart_write", {15'd0, wr_en, wr_addr}, {15'd0, 1'b1, 16'h0800});
    check("arst.restart_done", 32'(done), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
